// File: rtl/avr_cpu_fetch.sv
`default_nettype none
// ============================================================================
// Module  : avr_cpu_fetch
// Desc    : AVR fetch stage: program-memory addressing, word FIFO, 16/32-bit
//           instruction assembly. `define AVR_FETCH_STATS_EN adds counters.
// Rev     : 1.0
// ============================================================================
module avr_cpu_fetch #(
  parameter int                    ADDR_WIDTH   = 9,
  parameter int                    DATA_WIDTH   = 16,
  parameter int                    FIFO_DEPTH   = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] pm_addr,
  input  logic [DATA_WIDTH-1:0] pm_data,
  input  logic                  branch_valid,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  input  logic                  stall,
  output logic                  instr_valid,
  output logic [31:0]           instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_two_word
`ifdef AVR_FETCH_STATS_EN
  ,
  output logic [31:0]           stat_stall_cycles,
  output logic [31:0]           stat_bubble_cycles
`endif
);

  localparam int                  c_ptr_w    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int                  c_cnt_w    = c_ptr_w + 1;
  localparam logic [c_cnt_w:0]    c_depth    = (c_cnt_w + 1)'(FIFO_DEPTH);
  localparam logic [c_cnt_w-1:0]  c_one      = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0]  c_two      = c_cnt_w'(2);
  localparam logic [15:0]         c_lds_mask = 16'hFC0F;
  localparam logic [15:0]         c_lds_op   = 16'h9000;
  localparam logic [15:0]         c_jmp_mask = 16'hFE0C;
  localparam logic [15:0]         c_jmp_op   = 16'h940C;

  logic [ADDR_WIDTH-1:0] r_req_pc;
  logic                  r_inflight;
  logic [ADDR_WIDTH-1:0] r_inflight_pc;
  logic [DATA_WIDTH-1:0] r_fifo_data [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] r_fifo_pc   [FIFO_DEPTH];
  logic [c_ptr_w-1:0]    r_rd_ptr;
  logic [c_ptr_w-1:0]    r_wr_ptr;
  logic [c_cnt_w-1:0]    r_count;

  logic [c_ptr_w-1:0]    w_rd_next;
  logic [DATA_WIDTH-1:0] w_head_word;
  logic [DATA_WIDTH-1:0] w_second_word;
  logic                  w_two_word;
  logic                  w_valid;
  logic                  w_consume;
  logic [c_cnt_w-1:0]    w_pop_cnt;
  logic [c_cnt_w:0]      w_occ;
  logic                  w_issue;
  logic                  w_push;

  // Head decode: the second word of a two-word opcode is simply the next FIFO entry
  assign w_rd_next     = r_rd_ptr + 1'b1;
  assign w_head_word   = r_fifo_data[r_rd_ptr];
  assign w_second_word = r_fifo_data[w_rd_next];
  assign w_two_word    = ((w_head_word & c_lds_mask) == c_lds_op) ||
                         ((w_head_word & c_jmp_mask) == c_jmp_op);
  assign w_valid       = w_two_word ? (r_count >= c_two) : (r_count >= c_one);

  assign w_consume = w_valid && !stall && !branch_valid;
  assign w_pop_cnt = !w_consume ? '0 : (w_two_word ? c_two : c_one);

  // Occupancy ignores same-cycle pops so an issued word always has a slot
  assign w_occ   = {1'b0, r_count} + {{c_cnt_w{1'b0}}, r_inflight};
  assign w_issue = !branch_valid && (w_occ < c_depth);
  assign w_push  = r_inflight && !branch_valid;

  assign pm_addr        = r_req_pc;
  assign instr_valid    = w_valid;
  assign instr          = w_valid ? {w_head_word, (w_two_word ? w_second_word : 16'h0000)} : 32'h0;
  assign instr_pc       = w_valid ? r_fifo_pc[r_rd_ptr] : '0;
  assign instr_two_word = w_valid && w_two_word;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_req_pc      <= RESET_VECTOR;
      r_inflight    <= 1'b0;
      r_inflight_pc <= RESET_VECTOR;
    end else if (branch_valid) begin
      r_req_pc   <= branch_target;
      r_inflight <= 1'b0;
    end else if (w_issue) begin
      r_inflight    <= 1'b1;
      r_inflight_pc <= r_req_pc;
      r_req_pc      <= r_req_pc + 1'b1;
    end else begin
      r_inflight <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && w_push) begin
      r_fifo_data[r_wr_ptr] <= pm_data;
      r_fifo_pc[r_wr_ptr]   <= r_inflight_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || branch_valid) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      r_rd_ptr <= r_rd_ptr + w_pop_cnt[c_ptr_w-1:0];
      r_count  <= r_count + c_cnt_w'(w_push) - w_pop_cnt;
    end
  end

`ifdef AVR_FETCH_STATS_EN
  logic [31:0] r_stat_stall;
  logic [31:0] r_stat_bubble;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stat_stall  <= '0;
      r_stat_bubble <= '0;
    end else begin
      if (w_valid && stall && (r_stat_stall != 32'hFFFF_FFFF)) begin
        r_stat_stall <= r_stat_stall + 32'd1;
      end
      if (!w_valid && !stall && (r_stat_bubble != 32'hFFFF_FFFF)) begin
        r_stat_bubble <= r_stat_bubble + 32'd1;
      end
    end
  end

  assign stat_stall_cycles  = r_stat_stall;
  assign stat_bubble_cycles = r_stat_bubble;
`endif

endmodule
`default_nettype wire

// File: doc/avr_cpu_fetch.md
Name: avr_cpu_fetch

Overview:
Instruction fetch stage sitting between the AVR program memory and the decoder. It drives the program-memory address, absorbs the memory's 1-cycle synchronous read latency in a small word FIFO, and assembles 16-bit or 32-bit instructions. It presents those instructions to the decoder with a valid/stall handshake and redirects on branches.

Parameters:
ADDR_WIDTH, 9, program-memory word address width; PC width.
DATA_WIDTH, 16, program word width; fixed at 16 for AVR opcode detection.
FIFO_DEPTH, 4, word FIFO entries; power of two, minimum 2.
RESET_VECTOR, 0, PC loaded on reset.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
pm_addr  output  ADDR_WIDTH  program-memory read address; memory captures it on each rising edge
pm_data  input  DATA_WIDTH  program-memory read data; valid one cycle after the address is captured
branch_valid  input  1  redirect request from execute
branch_target  input  ADDR_WIDTH  redirect word address
stall  input  1  decoder not ready; current instruction is held
instr_valid  output  1  instr/instr_pc/instr_two_word are valid
instr  output  32  {first word, second word}; second word is 16'h0000 for single-word instructions
instr_pc  output  ADDR_WIDTH  word address of the instruction's first word
instr_two_word  output  1  instruction occupies two words

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low. While rst_n=0 at an edge:
  - req_pc <= RESET_VECTOR; FIFO emptied; inflight <= 0.
  - Outputs: instr_valid=0, pm_addr=RESET_VECTOR, instr=0, instr_pc=0, instr_two_word=0.
- pm_addr = req_pc, driven directly from a register.
- Issue at each edge: issue = !branch_valid && (count + inflight < FIFO_DEPTH). Pops in the same cycle are not credited.
  - If issue: inflight <= 1, inflight_pc <= req_pc, req_pc <= req_pc+1. The increment wraps modulo 2^ADDR_WIDTH.
  - Otherwise: inflight <= 0 and req_pc holds.
- Capture: if inflight=1 at an edge, {pm_data, inflight_pc} is pushed into the FIFO.
- Two-word detection on head word w:
  - (w & 16'hFC0F)==16'h9000 for LDS/STS.
  - (w & 16'hFE0C)==16'h940C for JMP/CALL.
- Output is combinational from the FIFO head.
  - Single-word: instr_valid = (count>=1).
  - Two-word: instr_valid = (count>=2). The second word is entry head+1; its PC is not checked beyond FIFO order.
  - instr_pc is the head entry's PC.
- Consume when instr_valid && !stall && !branch_valid: pop 1 word (single) or 2 words (two-word).
- Stall: outputs stay stable. Fetch continues until count+inflight reaches FIFO_DEPTH, then req_pc freezes. No word is ever dropped.
- Branch: branch_valid has priority over stall and consume. At that edge:
  - FIFO flushed, inflight <= 0, req_pc <= branch_target.
  - The instruction currently presented is discarded, not consumed.
- Latency:
  - First instr_valid occurs 2 edges after the first edge with rst_n=1.
  - Branch penalty is 2 bubble cycles. Steady-state throughput is 1 word per cycle.
- Wrap: a two-word instruction at the top address takes its second word from address 0.
- Simultaneous push and pop in the same edge are both honoured; count updates by push minus pop.

Optional Feature:
AVR_FETCH_STATS_EN:
- Defined: adds two output ports.
  - stat_stall_cycles, 32 bits: counts cycles with instr_valid && stall.
  - stat_bubble_cycles, 32 bits: counts cycles with !instr_valid && !stall.
  - Both counters clear on reset and saturate at 32'hFFFFFFFF.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. Memory filled with 16'h0000, stall=0, release reset: pm_addr steps 0,1,2,…; instr_valid rises at the 2nd edge; instr_pc is 0,1,2 on consecutive cycles; instr_two_word=0.
2. mem[5]=16'h940C, mem[6]=16'h0123: at instr_pc=5, instr=32'h940C0123 and instr_two_word=1; the next instruction has instr_pc=7.
3. Hold stall=1 for 6 cycles from instr_pc=2: outputs stay frozen; pm_addr freezes once count+inflight=4. After release, instr_pc runs 2,3,4,5,6 with no gaps or duplicates.
4. branch_valid=1 with branch_target=9'h040 while stalled: the pending instruction is dropped; instr_valid=0 for 2 cycles; the next valid instr_pc=9'h040 with no stale words.
5. Branch to 9'h1FF with mem[9'h1FF]=16'h9000, mem[0]=16'h0ABC: instr=32'h90000ABC, instr_pc=9'h1FF; the next instr_pc=1.
6. rst_n=0 for one edge while stalled with the FIFO full: instr_valid=0 and pm_addr=0 the next cycle. Normal fetch from 0 resumes with first valid 2 edges after release.
